// File: rtl/batalha_colisor_n.sv
// Battleship shot-resolution engine: per-player ship-ID grids with shot flags, a
// placement port, and a three-stage shot pipeline with sunk and game-over detection.
module batalha_colisor_n #(
  parameter int N         = 8,
  parameter int COORD_W   = 3,
  parameter int NUM_SHIPS = 4,
  parameter int ID_W      = 3,
  parameter int LEN_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               place_en,
  input  logic               place_jogador,
  input  logic [COORD_W-1:0] place_x,
  input  logic [COORD_W-1:0] place_y,
  input  logic [ID_W-1:0]    place_id,
  output logic               place_ok,
  output logic               place_conflict,
  input  logic               shot_valid,
  output logic               shot_ready,
  input  logic               shot_jogador,
  input  logic [COORD_W-1:0] shot_x,
  input  logic [COORD_W-1:0] shot_y,
  output logic               res_valid,
  output logic               res_hit,
  output logic               res_repeat,
  output logic               res_sunk,
  output logic               res_invalid,
  output logic [ID_W-1:0]    res_ship_id,
  output logic               game_over,
  output logic               winner
);

  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);
  localparam int TOT_W = $clog2(CELLS + 1);
  localparam int SHIPS_ALLOC = 2 ** ID_W;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_OVER} state_e;

  state_e state_q, state_d;

  // Board state, indexed [player][cell] / [player][ship id].
  logic [ID_W-1:0]  id_q    [2][CELLS];
  logic [CELLS-1:0] shot_q  [2];
  logic [LEN_W-1:0] rem_q   [2][SHIPS_ALLOC];
  logic [TOT_W-1:0] total_q [2];

  logic             shooter_q, sinv_q, lk_shot_q;
  logic [IDX_W-1:0] sidx_q;
  logic [ID_W-1:0]  lk_id_q;
  logic             place_ok_q, place_conflict_q;
  logic             res_valid_q, res_hit_q, res_repeat_q, res_sunk_q, res_invalid_q;
  logic [ID_W-1:0]  res_ship_id_q;
  logic             game_over_q, winner_q;

  logic             shot_fire, shot_in_range, place_in_range, place_id_ok, place_accept;
  logic [IDX_W-1:0] place_idx, shot_idx;
  logic             tgt, in_update, cls_invalid, cls_repeat, cls_miss, cls_hit;
  logic             hit_sunk, hit_last;

  assign shot_ready     = (state_q == S_IDLE);
  assign shot_fire      = shot_valid && shot_ready;
  assign shot_in_range  = (int'(shot_x) < N) && (int'(shot_y) < N);
  assign shot_idx       = IDX_W'(int'(shot_y) * N + int'(shot_x));
  assign place_in_range = (int'(place_x) < N) && (int'(place_y) < N);
  assign place_idx      = IDX_W'(int'(place_y) * N + int'(place_x));
  assign place_id_ok    = (place_id != '0) && (int'(place_id) <= NUM_SHIPS);

  // A shot accepted in the same cycle takes priority over a placement.
  assign place_accept = place_en && (state_q == S_IDLE) && !shot_fire &&
                        place_in_range && place_id_ok &&
                        (id_q[place_jogador][place_idx] == '0) &&
                        (rem_q[place_jogador][place_id] < LEN_MAX);

  assign tgt         = ~shooter_q;
  assign in_update   = (state_q == S_UPDATE);
  assign cls_invalid = sinv_q;
  assign cls_repeat  = !sinv_q && lk_shot_q;
  assign cls_miss    = !sinv_q && !lk_shot_q && (lk_id_q == '0);
  assign cls_hit     = !sinv_q && !lk_shot_q && (lk_id_q != '0);
  assign hit_sunk    = (rem_q[tgt][lk_id_q] == LEN_W'(1));
  assign hit_last    = (total_q[tgt] == TOT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (shot_fire) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = (cls_hit && hit_last) ? S_OVER : S_IDLE;
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the grids are flop arrays, not RAM, because a single reset edge must clear every cell.
      for (int p = 0; p < 2; p++) begin
        for (int c = 0; c < CELLS; c++) id_q[p][c] <= '0;
        for (int s = 0; s < SHIPS_ALLOC; s++) rem_q[p][s] <= '0;
        shot_q[p]  <= '0;
        total_q[p] <= '0;
      end
      shooter_q        <= 1'b0;
      sinv_q           <= 1'b0;
      sidx_q           <= '0;
      lk_id_q          <= '0;
      lk_shot_q        <= 1'b0;
      place_ok_q       <= 1'b0;
      place_conflict_q <= 1'b0;
      res_valid_q      <= 1'b0;
      res_hit_q        <= 1'b0;
      res_repeat_q     <= 1'b0;
      res_sunk_q       <= 1'b0;
      res_invalid_q    <= 1'b0;
      res_ship_id_q    <= '0;
      game_over_q      <= 1'b0;
      winner_q         <= 1'b0;
    end else begin
      place_ok_q       <= place_accept;
      place_conflict_q <= place_en && !place_accept;
      res_valid_q      <= in_update;

      if (shot_fire) begin
        shooter_q <= shot_jogador;
        sinv_q    <= !shot_in_range;
        sidx_q    <= shot_in_range ? shot_idx : '0;
      end

      if (state_q == S_LOOKUP) begin
        lk_id_q   <= id_q[tgt][sidx_q];
        lk_shot_q <= shot_q[tgt][sidx_q];
      end

      if (place_accept) begin
        id_q[place_jogador][place_idx]  <= place_id;
        rem_q[place_jogador][place_id]  <= rem_q[place_jogador][place_id] + LEN_W'(1);
        total_q[place_jogador]          <= total_q[place_jogador] + TOT_W'(1);
      end

      if (in_update) begin
        res_hit_q     <= cls_hit;
        res_repeat_q  <= cls_repeat;
        res_sunk_q    <= cls_hit && hit_sunk;
        res_invalid_q <= cls_invalid;
        res_ship_id_q <= cls_invalid ? '0 : lk_id_q;
        if (cls_miss || cls_hit) shot_q[tgt][sidx_q] <= 1'b1;
        if (cls_hit) begin
          rem_q[tgt][lk_id_q] <= rem_q[tgt][lk_id_q] - LEN_W'(1);
          total_q[tgt]        <= total_q[tgt] - TOT_W'(1);
          if (hit_last) begin
            game_over_q <= 1'b1;
            winner_q    <= shooter_q;
          end
        end
      end
    end
  end

  assign place_ok       = place_ok_q;
  assign place_conflict = place_conflict_q;
  assign res_valid      = res_valid_q;
  assign res_hit        = res_hit_q;
  assign res_repeat     = res_repeat_q;
  assign res_sunk       = res_sunk_q;
  assign res_invalid    = res_invalid_q;
  assign res_ship_id    = res_ship_id_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_batalha_colisor_n.sv
// Scoreboard bench for batalha_colisor_n on a 6x6 board: stimulus pushes expected
// placement and shot results into queues, a negedge monitor pops and compares them.
module tb_batalha_colisor_n;

  localparam int N = 6, COORD_W = 3, NUM_SHIPS = 4, ID_W = 3, LEN_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, place_en, place_jogador, place_ok, place_conflict;
  logic [COORD_W-1:0] place_x, place_y, shot_x, shot_y;
  logic [ID_W-1:0]    place_id, res_ship_id;
  logic               shot_valid, shot_ready, shot_jogador;
  logic               res_valid, res_hit, res_repeat, res_sunk, res_invalid;
  logic               game_over, winner;

  batalha_colisor_n #(.N(N), .COORD_W(COORD_W), .NUM_SHIPS(NUM_SHIPS), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .place_en(place_en), .place_jogador(place_jogador), .place_x(place_x), .place_y(place_y),
    .place_id(place_id), .place_ok(place_ok), .place_conflict(place_conflict),
    .shot_valid(shot_valid), .shot_ready(shot_ready), .shot_jogador(shot_jogador),
    .shot_x(shot_x), .shot_y(shot_y),
    .res_valid(res_valid), .res_hit(res_hit), .res_repeat(res_repeat), .res_sunk(res_sunk),
    .res_invalid(res_invalid), .res_ship_id(res_ship_id),
    .game_over(game_over), .winner(winner)
  );

  typedef struct packed {
    logic hit, rep, sunk, inv;
    logic [ID_W-1:0] id;
    logic go, win;
  } res_t;

  typedef struct packed { logic ok, conflict; } plc_t;

  res_t res_q[$];
  plc_t plc_q[$];
  res_t re;
  plc_t pe;
  int   tests = 0, fails = 0, sunk_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic hit, rep, sunk, inv, input int id, input logic go, win);
    mk = {hit, rep, sunk, inv, ID_W'(id), go, win};
  endfunction

  localparam res_t MISS = {4'b0000, 3'd0, 2'b00};
  localparam res_t INV  = {4'b0001, 3'd0, 2'b00};

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (place_ok || place_conflict) begin
      if (plc_q.size() == 0) check("unexpected_place_pulse", {place_ok, place_conflict}, 0);
      else begin
        pe = plc_q.pop_front();
        check("place_ok", place_ok, pe.ok);
        check("place_conflict", place_conflict, pe.conflict);
      end
    end
    if (res_valid) begin
      if (res_q.size() == 0) check("unexpected_res_valid", 1, 0);
      else begin
        re = res_q.pop_front();
        check("res_hit", res_hit, re.hit);
        check("res_repeat", res_repeat, re.rep);
        check("res_sunk", res_sunk, re.sunk);
        check("res_invalid", res_invalid, re.inv);
        check("res_ship_id", res_ship_id, re.id);
        check("game_over", game_over, re.go);
        if (re.go) check("winner", winner, re.win);
      end
      if (res_sunk) sunk_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic place(input logic pj, input int x, input int y, input int id, input logic ok);
    plc_t e;
    e = {ok, !ok};
    plc_q.push_back(e);
    place_en = 1'b1; place_jogador = pj;
    place_x = COORD_W'(x); place_y = COORD_W'(y); place_id = ID_W'(id);
    tick();
    place_en = 1'b0;
  endtask

  // mode 0: plain shot; 1: placement in the accept cycle; 2: placement during LOOKUP.
  task automatic shoot(input logic pj, input int x, input int y, input res_t e, input int mode);
    plc_t c;
    int   n;
    c = 2'b01;
    n = 0;
    while (!shot_ready && n < 10) begin
      tick();
      n++;
    end
    if (!shot_ready) begin
      check("shot_ready_timeout", 0, 1);
      return;
    end
    res_q.push_back(e);
    shot_valid = 1'b1; shot_jogador = pj; shot_x = COORD_W'(x); shot_y = COORD_W'(y);
    if (mode == 1) begin
      plc_q.push_back(c);
      place_en = 1'b1; place_jogador = 1'b0; place_x = 3'd4; place_y = 3'd4; place_id = 3'd1;
    end
    tick();
    shot_valid = 1'b0;
    place_en   = 1'b0;
    if (mode == 2) begin
      plc_q.push_back(c);
      place_en = 1'b1; place_jogador = 1'b0; place_x = 3'd4; place_y = 3'd3; place_id = 3'd1;
    end
    check("ready_in_lookup", shot_ready, 0);
    tick();
    place_en = 1'b0;
    check("res_valid_in_update", res_valid, 0);
    tick();
    check("res_latency", res_valid, 1);
    check("ready_after_result", shot_ready, !e.go);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int fleet [N*N];
    int rem [NUM_SHIPS+1];
    int total, id;
    res_t e;

    reset = 1'b1; place_en = 1'b0; place_jogador = 1'b0; place_x = '0; place_y = '0; place_id = '0;
    shot_valid = 1'b0; shot_jogador = 1'b0; shot_x = '0; shot_y = '0;
    tick();
    reset = 1'b0;
    check("rst_shot_ready", shot_ready, 1);
    check("rst_place_ok", place_ok, 0);
    check("rst_place_conflict", place_conflict, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_flags", {res_hit, res_repeat, res_sunk, res_invalid}, 0);
    check("rst_res_ship_id", res_ship_id, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);

    // Two-cell fleet for P2: hit, then sink and win for P1.
    place(1, 0, 0, 1, 1);
    place(1, 0, 1, 1, 1);
    shoot(0, 0, 0, mk(1, 0, 0, 0, 1, 0, 0), 0);
    shoot(0, 0, 1, mk(1, 0, 1, 0, 1, 1, 0), 0);
    tick();
    check("over_ready_low", shot_ready, 0);
    check("over_sticky", game_over, 1);
    place(0, 2, 2, 1, 0);
    shot_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    shot_valid = 1'b0;
    check("over_ignores_shot", shot_ready, 0);

    // Placement rules on P1's board.
    do_reset();
    place(0, 1, 1, 2, 1);
    place(0, 1, 1, 3, 0);
    place(0, 2, 2, 0, 0);
    place(0, 2, 2, 5, 0);
    place(0, 6, 0, 1, 0);
    for (int x = 0; x < N; x++) place(0, x, 5, 3, 1);
    place(0, 0, 4, 3, 1);
    place(0, 1, 4, 3, 0);
    place(0, 3, 3, 4, 1);
    place(0, 3, 3, 4, 0);

    shoot(1, 1, 1, mk(1, 0, 1, 0, 2, 0, 0), 0);
    shoot(1, 1, 4, MISS, 0);
    shoot(1, 2, 2, MISS, 0);
    shoot(1, 6, 0, INV, 0);
    shoot(1, 0, 7, INV, 0);
    shoot(1, 4, 0, MISS, 0);
    shoot(1, 4, 0, mk(0, 1, 0, 0, 0, 0, 0), 0);
    shoot(1, 1, 1, mk(0, 1, 0, 0, 2, 0, 0), 0);
    shoot(1, 3, 3, mk(1, 0, 1, 0, 4, 0, 0), 1);
    shoot(1, 4, 4, MISS, 2);
    shoot(1, 4, 3, MISS, 0);
    for (int x = 0; x < N; x++) shoot(1, x, 5, mk(1, 0, 0, 0, 3, 0, 0), 0);
    shoot(1, 0, 4, mk(1, 0, 1, 0, 3, 1, 1), 0);

    // Reset while a shot sits in LOOKUP.
    do_reset();
    place(1, 2, 2, 1, 1);
    shot_valid = 1'b1; shot_jogador = 1'b0; shot_x = 3'd2; shot_y = 3'd2;
    tick();
    shot_valid = 1'b0;
    check("midshot_in_lookup", shot_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midshot_ready_back", shot_ready, 1);
    tick();
    tick();
    check("midshot_no_result", res_valid, 0);
    shoot(0, 2, 2, MISS, 0);

    // Full sweep of a four-ship P2 fleet by P1.
    do_reset();
    sunk_seen = 0;
    for (int i = 0; i < N * N; i++) fleet[i] = 0;
    fleet[0] = 1;  fleet[1] = 1;
    fleet[12] = 2; fleet[13] = 2; fleet[14] = 2;
    fleet[27] = 4; fleet[28] = 4;
    fleet[35] = 3;
    for (int i = 0; i <= NUM_SHIPS; i++) rem[i] = 0;
    total = 0;
    for (int i = 0; i < N * N; i++) begin
      if (fleet[i] != 0) begin
        place(1, i % N, i / N, fleet[i], 1);
        rem[fleet[i]]++;
        total++;
      end
    end
    for (int y = 0; y < N; y++) begin
      for (int x = 0; x < N; x++) begin
        id = fleet[y * N + x];
        if (id != 0) begin
          rem[id]--;
          total--;
          e = mk(1, 0, rem[id] == 0, 0, id, total == 0, 0);
        end else begin
          e = MISS;
        end
        shoot(0, x, y, e, 0);
      end
    end
    tick();
    check("sweep_sunk_count", sunk_seen, NUM_SHIPS);
    check("sweep_game_over", game_over, 1);
    shot_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    shot_valid = 1'b0;
    tick();
    check("res_queue_drained", res_q.size(), 0);
    check("place_queue_drained", plc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/batalha_colisor_n.md
# batalha_colisor_n

Parametrised shot-resolution engine for the two-player Battleship game. It holds both players' fleets as an N×N grid of ship IDs with per-cell "shot" flags, and accepts ship-cell placements from the placement/validation stage. It resolves shots from the game-execution FSM through a valid/ready handshake, reporting miss, hit, repeat, sunk and game over. It replaces the fixed 8×8 single-flag collider with configurable board size and fleet size, plus sunk and winner detection.

## Interface
- `N`, 8: board side; grid is N×N per player (2 ≤ N ≤ 16).
- `COORD_W`, 3: coordinate width; requires 2^COORD_W ≥ N.
- `NUM_SHIPS`, 4: ships per player; valid IDs are 1..NUM_SHIPS, and ID 0 means water.
- `ID_W`, 3: ship-ID width; requires 2^ID_W > NUM_SHIPS.
- `LEN_W`, 3: per-ship remaining-cell counter width; a ship has at most 2^LEN_W−1 cells.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset. Both grids, all flags and all counters are cleared on the same edge.
- `place_en` in 1: single-cycle request to write one ship cell.
- `place_jogador` in 1: board owner (0 = P1, 1 = P2).
- `place_x`, `place_y` in COORD_W: cell to write.
- `place_id` in ID_W: ship ID for the cell.
- `place_ok` out 1: one-cycle pulse; the cell was written.
- `place_conflict` out 1: one-cycle pulse; the write was rejected.
- `shot_valid` in 1: a shot is offered.
- `shot_ready` out 1: the engine can accept a shot.
- `shot_jogador` in 1: the shooter; the target board is the other player's.
- `shot_x`, `shot_y` in COORD_W: shot coordinates.
- `res_valid` out 1: one-cycle pulse; the result fields are valid.
- `res_hit`, `res_repeat`, `res_sunk`, `res_invalid` out 1: result flags.
- `res_ship_id` out ID_W: ship ID at the target cell (0 on a miss).
- `game_over` out 1: sticky; set when the target's fleet is fully hit.
- `winner` out 1: the shooter that ended the game. Valid only while `game_over` is 1.

## Operation
- **State.** Each player has the following:
  - `id[N*N]` (ID_W bits each);
  - `shot[N*N]` (1 bit each);
  - `rem[NUM_SHIPS]` (LEN_W bits each);
  - `total` (width clog2(N*N+1)).
- **FSM states:** IDLE → LOOKUP → UPDATE → IDLE, plus the absorbing state OVER.
- **`shot_ready`** is 1 only in IDLE.
- **Placement** is evaluated only in IDLE.
  - Accepted when all of the following hold: the cell is in range (x < N and y < N), place_id is in 1..NUM_SHIPS, the target cell is 0, and rem[place_id] < 2^LEN_W−1.
  - On acceptance: id ← place_id, rem[place_id] +1, total +1, and `place_ok` pulses.
  - Otherwise `place_conflict` pulses.
  - In LOOKUP, UPDATE or OVER, `place_en` produces `place_conflict` and no write.
- **Shot accept** happens on an edge where `shot_valid` and `shot_ready` are both 1. The engine registers the shooter and coordinates, then goes to LOOKUP.
- **LOOKUP** registers the target's `id` and `shot` values for the cell.
- **UPDATE** classifies the shot, in this priority order:
  1. **invalid:** coordinate ≥ N. Sets `res_invalid`; no state changes.
  2. **repeat:** `shot` flag already 1. Sets `res_repeat`, returns `res_ship_id` of the cell, and clears `res_hit`. No state changes.
  3. **miss:** id == 0. Sets the `shot` flag; `res_hit` = 0.
  4. **hit:** Sets the `shot` flag, rem[id] −1 and total −1, and `res_hit` = 1. `res_sunk` = 1 when rem[id] becomes 0. When total becomes 0, the engine sets `game_over` = 1 and `winner` = shooter, and moves to OVER instead of IDLE.
- **Result fields** hold their values until the next `res_valid`.
- **Empty fleet:** a target with total == 0 before any hit never triggers `game_over`, because a miss does not decrement anything.
- **OVER:** `shot_ready` = 0 and placement is rejected. Only `reset` leaves OVER.

## Timing
- **Reset values:**
  - `shot_ready` = 1;
  - every other output = 0, including `place_ok`, `place_conflict`, `res_*`, `game_over` and `winner`;
  - FSM in IDLE.
- **Shot latency:** accept at edge k; `res_valid` is high in the cycle after edge k+2. The FSM is back in IDLE after that same edge, so `shot_ready` is 1 again. Maximum throughput is one shot every 3 cycles.
- **`place_ok` / `place_conflict`:** registered, high for the single cycle after the edge that samples `place_en`.
- **Simultaneous `place_en` and an accepted shot in IDLE:** the shot wins and the placement gets `place_conflict`.
- **Two placements:** consecutive-cycle placements are both evaluated. A second write to the same cell sees the first write and is rejected.
- **Reset mid-shot (LOOKUP or UPDATE):** the shot is dropped, no `res_valid` is produced, and all state clears.
- **Register updates:** `game_over`, `winner` and the FSM state all change on the same edge that raises `res_valid`.

## Test plan
- **Reset, then P2 placements.** Place P2 ship 1 at (0,0) and (0,1). P1 shoots (0,0): `res_valid` 2 cycles after accept, hit=1, sunk=0, id=1. P1 shoots (0,1): hit=1, sunk=1, `game_over`=1, `winner`=0, `shot_ready` stays 0.
- **Miss then repeat.** P1 shoots water (3,3): hit=0, id=0. Same shot again: repeat=1, hit=0. `total` unchanged, and a later sinking still requires every ship cell.
- **Placement conflicts:** writing an occupied cell, place_id=0, place_id=NUM_SHIPS+1, x=N (with N=6) or the (2^LEN_W)th cell of one ship → `place_conflict` each time, and the grid is unchanged.
- **Contention:** `place_en` and `shot_valid` in the same IDLE cycle → shot result correct, `place_conflict`=1. `place_en` during LOOKUP → `place_conflict`.
- **Reset mid-shot:** assert `reset` in LOOKUP → no `res_valid`; next cycle `shot_ready`=1 and all cells read as water.
- **N=10, COORD_W=4, NUM_SHIPS=5:** place a 5-ship fleet, sweep all 100 shots → exactly 5 `res_sunk` pulses, `game_over` on the last ship cell, and subsequent `shot_valid` is ignored.
